mux_display_capture: RTL and testbench

//  Receive side of the multiplexed 4-digit 7-segment display bus (anode_n/seg_n).

---
 rtl/display_pkg.sv | 27 ++
 rtl/seg7_decode.sv | 35 +++
 rtl/mux_display_capture.sv | 139 +++++++++++++
 tb/tb_mux_display_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display bus: active-low
// gfedcba glyphs for hex 0..F plus the idle (blank) bus values.
package display_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [3:0] ANODE_BLANK = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment glyph to hex decoder. Patterns that are not one of
// the sixteen hex glyphs decode as 4'hF with illegal set.
module seg7_decode
  import display_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] hex,
  output logic       illegal
);

  always_comb begin
    hex     = 4'hF;
    illegal = 1'b0;
    case (seg_n)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mux_display_capture.sv
// Receive side of a scanned 4-digit 7-segment bus: samples each settled dwell,
// rebuilds the displayed hex value and flags frame, order and pattern errors.
module mux_display_capture #(
  parameter int NDIG    = 4,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NDIG-1:0]     anode_n,
  input  logic [6:0]          seg_n,
  input  logic                clr,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     seg_err,
  output logic                frame_valid,
  output logic                seq_err,
  output logic                onehot_err,
  output logic                stale
);

  import display_pkg::SEG_BLANK;

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [NDIG-1:0] anode_q, anode_d;
  logic [6:0]      seg_q, seg_d;
  logic [SW-1:0]   scnt;
  logic [TW-1:0]   tcnt;
  logic            lock;
  logic [1:0]      prev;
  logic [NDIG-1:0] seen;
  logic            chg, strobe, one_low, multi_low, capture;
  logic [1:0]      idx;
  logic [NDIG-1:0] idx_bit, seen_nxt;
  logic [3:0]      hex;
  logic            illegal;

  // Stage 0: bus input register plus a delayed copy for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_q <= '1;
      anode_d <= '1;
      seg_q   <= SEG_BLANK;
      seg_d   <= SEG_BLANK;
    end else begin
      anode_q <= anode_n;
      anode_d <= anode_q;
      seg_q   <= seg_n;
      seg_d   <= seg_q;
    end
  end

  always_comb begin
    chg       = (anode_q != anode_d) || (seg_q != seg_d);
    strobe    = !chg && (scnt == SW'(SETTLE - 1));
    one_low   = ($countones(~anode_q) == 1);
    multi_low = ($countones(~anode_q) > 1);
    capture   = strobe && one_low;
    idx       = 2'd0;
    for (int i = 0; i < NDIG; i++)
      if (!anode_q[i]) idx = i[1:0];
    idx_bit   = NDIG'(1) << idx;
    seen_nxt  = seen | idx_bit;
  end

  seg7_decode u_dec (
    .seg_n   (seg_q),
    .hex     (hex),
    .illegal (illegal)
  );

  // Stage 1: settle counter; saturation limits sampling to once per dwell
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scnt <= '0;
    else if (chg)
      scnt <= '0;
    else if (scnt != SW'(SETTLE))
      scnt <= scnt + 1'b1;
  end

  // Stage 2: capture, scan-order tracking and timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= '0;
      seg_err     <= '0;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      onehot_err  <= 1'b0;
      stale       <= 1'b0;
      tcnt        <= '0;
      lock        <= 1'b0;
      prev        <= 2'd0;
      seen        <= '0;
    end else begin
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;

      if (strobe && multi_low)
        onehot_err <= 1'b1;
      else if (clr)
        onehot_err <= 1'b0;

      if (capture) begin
        digits[{idx, 2'b00} +: 4] <= hex;
        seg_err[idx]              <= illegal;
        prev                      <= idx;
        tcnt                      <= '0;
        stale                     <= 1'b0;
        if (!lock) begin
          lock <= 1'b1;
          seen <= idx_bit;
        end else if (idx == prev + 2'd1) begin
          // Only the 3->0 wrap opens a frame, so completion lands on digit 3
          if (idx == 2'd0)
            seen <= idx_bit;
          else if (seen_nxt == '1) begin
            frame_valid <= 1'b1;
            seen        <= '0;
          end else
            seen <= seen_nxt;
        end else begin
          seq_err <= 1'b1;
          seen    <= idx_bit;
        end
      end else begin
        if (tcnt != TW'(TIMEOUT))
          tcnt <= tcnt + 1'b1;
        if (tcnt == TW'(TIMEOUT - 1)) begin
          stale <= 1'b1;
          lock  <= 1'b0;
          seen  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_display_capture.sv
// Randomized and directed bench for mux_display_capture with a cycle-level
// behavioural model of the receiver.
module tb_mux_display_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  seg_err;
  logic        frame_valid, seq_err, onehot_err, stale;

  always #5 clk = ~clk;

  mux_display_capture #(.NDIG(4), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .anode_n(anode_n), .seg_n(seg_n), .clr(clr),
    .digits(digits), .seg_err(seg_err), .frame_valid(frame_valid),
    .seq_err(seq_err), .onehot_err(onehot_err), .stale(stale)
  );

  // Active-low gfedcba glyphs, index = hex value
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_chk = 0, n_err = 0;
  int fv_obs = 0, se_obs = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int         edge_n = 0;
  logic [3:0] m_dig [4];
  logic [3:0] m_serr;
  logic       m_fv, m_se, m_oh, m_stale;
  int         last_cap;
  bit         locked;
  int         prev_idx;
  int         frame_q [$];
  logic [10:0] prev_bus, pend_bus;
  int         run;
  bit         pend;

  function automatic int glyph_value(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (glyph[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [3:0] anode_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_serr = 4'h0; m_fv = 0; m_se = 0; m_oh = 0; m_stale = 0;
    locked = 0; prev_idx = 0; frame_q.delete();
    prev_bus = {4'hF, 7'h7F}; run = 0; pend = 0; pend_bus = '0;
    last_cap = edge_n;
  endtask

  // One clock edge of the receiver: a bus value held unchanged over SETTLE+1
  // edges is sampled on the following edge.
  task automatic model_edge();
    logic [3:0]  a;
    logic [6:0]  s;
    logic [10:0] cur;
    int nl, idx, g;
    bit cap, multi;
    edge_n++;
    if (rst) begin
      model_reset();
      return;
    end
    m_fv = 0; m_se = 0; cap = 0; multi = 0;
    if (pend) begin
      a = pend_bus[10:7];
      s = pend_bus[6:0];
      nl = 0; idx = 0;
      for (int i = 0; i < 4; i++)
        if (!a[i]) begin nl++; idx = i; end
      if (nl > 1) begin
        multi = 1;
        m_oh = 1;
      end else if (nl == 1) begin
        g = glyph_value(s);
        m_dig[idx] = (g < 0) ? 4'hF : g[3:0];
        m_serr[idx] = (g < 0);
        cap = 1; last_cap = edge_n; m_stale = 0;
        if (!locked) begin
          locked = 1;
          frame_q.delete(); frame_q.push_back(idx);
        end else if (idx == (prev_idx + 1) % 4) begin
          if (idx == 0) frame_q.delete();
          frame_q.push_back(idx);
          if (frame_q.size() == 4) begin
            m_fv = 1;
            frame_q.delete();
          end
        end else begin
          m_se = 1;
          frame_q.delete(); frame_q.push_back(idx);
        end
        prev_idx = idx;
      end
    end
    if (!multi && clr) m_oh = 0;
    if (!cap && (edge_n - last_cap == TIMEOUT)) begin
      m_stale = 1; locked = 0; frame_q.delete();
    end
    cur = {anode_n, seg_n};
    run = (cur == prev_bus) ? run + 1 : 1;
    prev_bus = cur;
    pend = (run == SETTLE + 1);
    pend_bus = cur;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_eq("digits", digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    chk_eq("seg_err", seg_err, m_serr);
    chk_eq("frame_valid", frame_valid, m_fv);
    chk_eq("seq_err", seq_err, m_se);
    chk_eq("onehot_err", onehot_err, m_oh);
    chk_eq("stale", stale, m_stale);
    if (frame_valid) fv_obs++;
    if (seq_err) se_obs++;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    anode_n = a;
    seg_n   = s;
    repeat (len) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_eq("rst_digits", digits, 16'h0);
    chk_eq("rst_seg_err", seg_err, 4'h0);
    chk_eq("rst_flags", {frame_valid, seq_err, onehot_err, stale}, 4'h0);
    repeat (2) tick();
    rst = 1'b0;
  endtask

  int fv0, se0, ring;
  logic [15:0] saved;

  initial begin
    rst = 1'b1; clr = 1'b0; anode_n = 4'hF; seg_n = 7'h7F;
    model_reset();
    repeat (3) tick();
    chk_eq("reset_digits", digits, 16'h0);
    chk_eq("reset_flags", {seg_err, frame_valid, seq_err, onehot_err, stale}, 8'h0);
    rst = 1'b0;

    // Normal scan of 1,2,3,4
    fv0 = fv_obs; se0 = se_obs;
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) dwell(anode_of(d), glyph[d + 1], 16);
    chk_eq("t1_digits", digits, 16'h4321);
    chk_eq("t1_frames", fv_obs - fv0, 3);
    chk_eq("t1_seq", se_obs - se0, 0);

    // Dwell shorter than settle: no samples, stale, then recovery
    saved = digits;
    for (int k = 0; k < 550; k++) dwell(anode_of(k % 4), glyph[k % 16], 2);
    chk_eq("t2_stale_set", stale, 1);
    chk_eq("t2_digits_held", digits, saved);
    dwell(anode_of(0), glyph[5], 16);
    chk_eq("t2_stale_clr", stale, 0);
    chk_eq("t2_digit0", digits[3:0], 4'h5);

    // Two anodes low: sticky error, set beats clr
    saved = digits;
    dwell(4'hF, 7'h7F, 8);
    dwell(4'b1100, glyph[7], 16);
    chk_eq("t3_onehot", onehot_err, 1);
    chk_eq("t3_digits_held", digits, saved);
    dwell(4'hF, 7'h7F, 8);
    anode_n = 4'b1100; seg_n = glyph[7];
    repeat (SETTLE + 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    chk_eq("t3_set_wins", onehot_err, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_eq("t3_clr", onehot_err, 0);

    // Out-of-order digit
    do_reset();
    fv0 = fv_obs; se0 = se_obs;
    dwell(anode_of(0), glyph[9], 16);
    dwell(anode_of(1), glyph[10], 16);
    dwell(anode_of(3), glyph[11], 16);
    chk_eq("t4_seq", se_obs - se0, 1);
    chk_eq("t4_digit3", digits[15:12], 4'hB);
    chk_eq("t4_no_frame", fv_obs - fv0, 0);
    for (int d = 0; d < 4; d++) dwell(anode_of(d), glyph[d + 12], 16);
    chk_eq("t4_frame", fv_obs - fv0, 1);

    // Illegal glyph on digit 2
    dwell(anode_of(0), glyph[1], 16);
    dwell(anode_of(1), glyph[2], 16);
    dwell(anode_of(2), 7'b1111110, 16);
    dwell(anode_of(3), glyph[4], 16);
    chk_eq("t5_seg_err", seg_err, 4'b0100);
    chk_eq("t5_digit2", digits[11:8], 4'hF);

    // Reset mid-dwell after three captures
    for (int d = 0; d < 3; d++) dwell(anode_of(d), glyph[d + 6], 16);
    dwell(anode_of(3), glyph[9], 3);
    do_reset();
    fv0 = fv_obs;
    for (int d = 0; d < 3; d++) dwell(anode_of(d), glyph[d + 2], 16);
    chk_eq("t6_no_frame", fv_obs - fv0, 0);
    dwell(anode_of(3), glyph[5], 16);
    chk_eq("t6_frame", fv_obs - fv0, 1);
    chk_eq("t6_digits", digits, 16'h5432);

    // Randomized bus traffic
    ring = 0;
    for (int k = 0; k < 400; k++) begin
      logic [3:0] a;
      logic [6:0] s;
      if ($urandom_range(0, 9) < 7) begin
        a = anode_of(ring % 4);
        ring++;
      end else
        a = 4'($urandom);
      s = ($urandom_range(0, 7) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      clr = ($urandom_range(0, 9) == 0);
      dwell(a, s, $urandom_range(1, 20));
    end
    clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
